// File: rtl/dff_force_scheduler.sv
// dff_force_scheduler: round-robin arbiter that forces timed values onto a shared falling-edge register
// Ports: clk (state updates on falling edge), reset (asynchronous, active low), d_in (normal datapath input),
//   req/req_val/req_hold (per-requester request level, force value and hold count, packed by requester),
//   q/qbar (register and its complement), gnt (one-hot owner of the forced value),
//   done (one-cycle pulse after a completed hold), busy (scheduler not idle).
module dff_force_scheduler #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         d_in,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_val,
  input  logic [NREQ*HOLD_W-1:0]   req_hold,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
  state_t            state_q;
  logic [WIDTH-1:0]  q_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [IW-1:0]     ptr_q, own_q, win, idx;
  logic [NREQ-1:0]   gnt_q, done_q;
  logic              busy_q, hit;
  // Scan downward so the last match written is the first set bit at or after ptr_q.
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            q_q     <= req_val[int'(win)*WIDTH +: WIDTH];
            cnt_q   <= req_hold[int'(win)*HOLD_W +: HOLD_W];
            gnt_q   <= NREQ'(1) << win;
            own_q   <= win;
            ptr_q   <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            busy_q  <= 1'b1;
            state_q <= HOLD;
          end else begin
            q_q <= d_in;
          end
        end
        HOLD: begin
          // Abort wins over completion; only a completed hold reports done.
          if (!req[own_q] || cnt_q == '0) begin
            q_q     <= d_in;
            gnt_q   <= '0;
            done_q  <= req[own_q] ? gnt_q : '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          q_q     <= d_in;
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign q    = q_q;
  assign qbar = ~q_q;
  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_dff_force_scheduler.sv
// tb_dff_force_scheduler: scoreboard bench for the round-robin force scheduler
module tb_dff_force_scheduler;
  logic        clk;
  logic        reset;
  logic [7:0]  d_in;
  logic [3:0]  req;
  logic [31:0] req_val;
  logic [15:0] req_hold;
  logic [7:0]  q, qbar;
  logic [3:0]  gnt, done;
  logic        busy;
  dff_force_scheduler #(.NREQ(4), .WIDTH(8), .HOLD_W(4)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .req(req), .req_val(req_val),
    .req_hold(req_hold), .q(q), .qbar(qbar), .gnt(gnt), .done(done), .busy(busy)
  );
  typedef struct {
    logic [3:0] g;
    logic [7:0] v;
    int         len;
    logic [3:0] dn;
    int         gap;
  } rec_t;
  rec_t       exp_q[$];
  rec_t       cur;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_g = 0;
  int         len = 0;
  bit         active = 0;
  logic [7:0] nq;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Monitor: samples on the rising edge, midway between the DUT's falling-edge updates.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) begin
      active = 0;
      continue;
    end
    nq = ~q;
    chk("qbar", qbar, nq);
    if (active) begin
      if (gnt == cur.g) begin
        len++;
        chk("hold_q", q, cur.v);
        chk("hold_busy", busy, 1);
      end else begin
        if (cur.len > 0) chk("hold_len", len, cur.len);
        chk("done", done, cur.dn);
        chk("gnt_off", gnt, 0);
        chk("q_release", q, d_in);
        chk("busy_done", busy, 1);
        active = 0;
      end
    end else if (gnt != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", gnt, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("gnt", gnt, cur.g);
        chk("grant_q", q, cur.v);
        if (cur.gap > 0) chk("gap", cyc - last_g, cur.gap);
        last_g = cyc;
        active = 1;
        len = 1;
      end
    end else begin
      chk("idle_done", done, 0);
      chk("idle_q", q, d_in);
      chk("idle_busy", busy, 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b0;
    d_in = 8'h3C;
    req = '0;
    req_val = '0;
    req_hold = '0;
    #1;
    chk("init_q", q, 8'h00);
    chk("init_qbar", qbar, 8'hFF);
    chk("init_gnt", gnt, 0);
    chk("init_busy", busy, 0);
    tick(2);
    reset = 1'b1;
    tick(3);
    // Single force: requester 2, value A5, hold 3 -> four forced cycles then done.
    exp_q.push_back('{4'b0100, 8'hA5, 4, 4'b0100, 0});
    req_val[16 +: 8] = 8'hA5;
    req_hold[8 +: 4] = 4'd3;
    req = 4'b0100;
    tick(5);
    req = '0;
    tick(3);
    // Reset mid-hold: requester 1 granted (pointer at 3), then async reset.
    exp_q.push_back('{4'b0010, 8'h66, 0, 4'b0000, 0});
    req_val[8 +: 8] = 8'h66;
    req_hold[4 +: 4] = 4'd10;
    req = 4'b0010;
    tick(3);
    reset = 1'b0;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", qbar, 8'hFF);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    req = '0;
    tick(1);
    reset = 1'b1;
    tick(2);
    d_in = 8'h81;
    tick(2);
    // Round-robin from pointer 0 after reset, zero holds: 0,1,2,3,0 three cycles apart.
    exp_q.push_back('{4'b0001, 8'h11, 1, 4'b0001, 0});
    exp_q.push_back('{4'b0010, 8'h22, 1, 4'b0010, 3});
    exp_q.push_back('{4'b0100, 8'h33, 1, 4'b0100, 3});
    exp_q.push_back('{4'b1000, 8'h44, 1, 4'b1000, 3});
    exp_q.push_back('{4'b0001, 8'h11, 1, 4'b0001, 3});
    req_val = 32'h44332211;
    req_hold = 16'h0000;
    req = 4'b1111;
    tick(15);
    req = '0;
    tick(3);
    // Zero hold on requester 1 (pointer now 1): forced one cycle.
    exp_q.push_back('{4'b0010, 8'h5A, 1, 4'b0010, 0});
    req_val[8 +: 8] = 8'h5A;
    req_hold[4 +: 4] = 4'd0;
    req = 4'b0010;
    tick(2);
    req = '0;
    tick(3);
    // Max hold on requester 3: forced exactly 16 cycles.
    exp_q.push_back('{4'b1000, 8'hC3, 16, 4'b1000, 0});
    req_val[24 +: 8] = 8'hC3;
    req_hold[12 +: 4] = 4'd15;
    req = 4'b1000;
    tick(17);
    req = '0;
    tick(3);
    // Abort: requester 1 drops after two forced cycles; requester 2 served four cycles after its grant.
    exp_q.push_back('{4'b0010, 8'h77, 2, 4'b0000, 0});
    exp_q.push_back('{4'b0100, 8'h99, 2, 4'b0100, 4});
    req_val[8 +: 8] = 8'h77;
    req_hold[4 +: 4] = 4'd10;
    req_val[16 +: 8] = 8'h99;
    req_hold[8 +: 4] = 4'd1;
    d_in = 8'h5C;
    req = 4'b0110;
    tick(2);
    req = 4'b0100;
    tick(6);
    req = '0;
    tick(3);
    // Late change of value and hold during the hold must be ignored.
    exp_q.push_back('{4'b0001, 8'h0F, 4, 4'b0001, 0});
    req_val[0 +: 8] = 8'h0F;
    req_hold[0 +: 4] = 4'd3;
    req = 4'b0001;
    tick(2);
    req_val[0 +: 8] = 8'hF0;
    req_hold[0 +: 4] = 4'd15;
    tick(3);
    req = '0;
    tick(3);
    for (int i = 0; i < 50 && (exp_q.size() != 0 || active); i++) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("monitor_idle", active, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dff_force_scheduler.md
# dff_force_scheduler

Controller that shares one WIDTH-bit negedge register, with true and complement outputs, among NREQ requesters that each want to force a value onto it. Each forced value is held for a programmable number of clock cycles, after which the register goes back to tracking its normal datapath input. Requesters are served round-robin. The block sits between the test/override logic and the flip-flop bank, replacing ad-hoc force/release of the register.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, register width
- HOLD_W, 4, width of per-requester hold count

Ports:
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-low reset
- d_in  in  WIDTH  normal datapath input, captured when not forced
- req  in  NREQ  level request, one bit per requester
- req_val  in  NREQ*WIDTH  force value; requester i uses slice [i*WIDTH +: WIDTH]
- req_hold  in  NREQ*HOLD_W  hold count; requester i uses slice [i*HOLD_W +: HOLD_W]
- q  out  WIDTH  register output
- qbar  out  WIDTH  always ~q
- gnt  out  NREQ  one-hot grant, high while requester's value is forced
- done  out  NREQ  one-cycle pulse on completed (non-aborted) hold
- busy  out  1  high when state != IDLE

## Operation
- States:
  - IDLE: q <= d_in at every edge.
  - HOLD: q frozen at granted req_val.
  - DONE: q <= d_in; gnt = 0.
- Arbitration, in IDLE only:
  - Search req from rr pointer ptr upward, wrapping modulo NREQ; first set bit i wins.
  - At that edge: q <= req_val[i], cnt <= req_hold[i], gnt <= one-hot(i), ptr <= (i+1) mod NREQ, state <= HOLD.
  - req_val/req_hold are sampled only at the grant edge; later changes are ignored.
- HOLD:
  - If req[i] == 0 at an edge: abort → DONE, no done pulse.
  - Else if cnt != 0: cnt <= cnt - 1.
  - Else (cnt == 0): → DONE with done[i] asserted for the DONE cycle.
  - Abort has priority over completion in the same edge.
- DONE: unconditional → IDLE at next edge; no arbitration in DONE.
- Requests arriving during HOLD/DONE wait; ptr guarantees each active requester is served within NREQ grants.
- req_hold = 0 is legal: forced value visible for exactly 1 cycle.
- Max hold = 2^HOLD_W cycles; cnt never wraps below 0.
- gnt is one-hot or zero. done is one-hot or zero, and only ever set in DONE.
- Reset (reset = 0, any time, asynchronous):
  - q = 0, qbar = all ones, gnt = 0, done = 0, busy = 0.
  - cnt = 0, ptr = 0, state = IDLE.
  - Holds in progress are discarded with no done pulse.

## Timing
- Grant latency: req[i] high, sampled in IDLE at falling edge k → gnt[i], busy and q = req_val[i] valid after edge k.
- Forced value visible for req_hold + 1 cycles (edges k .. k+h).
- Edge k+h+1: q <= d_in, gnt = 0, done[i] = 1 for one cycle.
- Edge k+h+2: state IDLE. Earliest next grant at edge k+h+3.
- Abort: req[i] low sampled at edge m in HOLD → gnt = 0 and q = d_in after edge m; IDLE after m+1.
- qbar is combinational ~q, with zero latency.
- Reset release: first arbitration at the first falling edge where reset = 1.

## Test plan
- Reset: drive reset = 0 mid-HOLD → q = 0x00, qbar = 0xFF, gnt = 0, busy = 0 immediately, without waiting for a clock edge. After release, first request goes to req[0] (ptr = 0).
- Single force: req[2] = 1, req_val[2] = 0xA5, req_hold[2] = 3 → q = 0xA5 for 4 falling-edge cycles, gnt = 4'b0100. Then done[2] pulses for 1 cycle and q follows d_in = 0x3C.
- Round-robin: req = 4'b1111 held, all holds = 0 → grant order 0,1,2,3,0, with each grant 3 cycles apart (HOLD, DONE, IDLE).
- Zero-hold/max-hold: hold = 0 → forced 1 cycle; hold = 15 → forced exactly 16 cycles with no counter wrap.
- Abort: req[1] drops 2 cycles into a hold of 10 → gnt = 0 and q = d_in after that edge, done stays 0, next requester is served after DONE.
- Late input change: req_val[0] changes during HOLD → q unchanged; qbar == ~q at every sample.
